// File: rtl/div_pkg.sv
// Shared types for the iterative signed divider.
// Holds the divider FSM state encoding.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 signed divider, truncating toward zero.
// Ports: clk, rst_n, in_valid/in_ready, n, d, out_valid/out_ready, q, r, div_by_zero.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH_N = 32,
  parameter int WIDTH_D = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] n,
  input  logic [WIDTH_D-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] q,
  output logic [WIDTH_D-1:0] r,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH_N) + 1;

  div_state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] an;
  logic [WIDTH_D-1:0] ad;
  logic [WIDTH_D:0]   pr;
  logic               sn;
  logic               sd;
  logic               dz;

  logic [WIDTH_D:0]   sh;
  logic               ge;
  logic               acc;
  logic [WIDTH_N-1:0] qf;
  logic [WIDTH_D-1:0] rf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign acc       = in_valid && in_ready;

  // an doubles as dividend shifter and quotient collector
  assign sh = {pr[WIDTH_D-1:0], an[WIDTH_N-1]};
  assign ge = (sh >= {1'b0, ad});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc) state_nx = CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    qf = an;
    rf = pr[WIDTH_D-1:0];
    if (sn ^ sd) qf = -an;
    if (sn)      rf = -pr[WIDTH_D-1:0];
    if (dz) begin
      qf = '1;
      rf = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      an          <= '0;
      ad          <= '0;
      pr          <= '0;
      sn          <= 1'b0;
      sd          <= 1'b0;
      dz          <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (acc) begin
        an  <= n[WIDTH_N-1] ? -n : n;
        ad  <= d[WIDTH_D-1] ? -d : d;
        sn  <= n[WIDTH_N-1];
        sd  <= d[WIDTH_D-1];
        dz  <= (d == '0);
        pr  <= '0;
        cnt <= CW'(WIDTH_N);
      end else if (state == CALC && cnt != '0) begin
        pr  <= ge ? (sh - {1'b0, ad}) : sh;
        an  <= {an[WIDTH_N-2:0], ge};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        q           <= qf;
        r           <= rf;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (WIDTH_N=32, WIDTH_D=16).
// Checks latency, signs, div-by-zero, overflow, hold and reset.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [15:0] r;
  logic        div_by_zero;

  int n_chk;
  int n_fail;

  div_seq #(.WIDTH_N(32), .WIDTH_D(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .n           (n),
    .d           (d),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] nv,
                       input logic [15:0] dv);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    check("rdy_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    n = nv;
    d = dv;
    tick();
    in_valid = 1'b0;
    n = $urandom;
    d = 16'($urandom);
  endtask

  task automatic do_div(input string tag,
                        input logic [31:0] nv,
                        input logic [15:0] dv,
                        input logic [31:0] eq,
                        input logic [15:0] er,
                        input logic ez,
                        input bit hold);
    int lat;
    logic [31:0] q0;
    logic [15:0] r0;
    out_ready = !hold;
    issue(nv, dv);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd34);
    check({tag, "_q"}, {32'd0, q}, {32'd0, eq});
    check({tag, "_r"}, {48'd0, r}, {48'd0, er});
    check({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, ez});
    if (hold) begin
      q0 = q;
      r0 = r;
      for (int i = 0; i < 10; i++) begin
        in_valid = i[0];
        n = 32'd77;
        d = 16'd11;
        tick();
        check({tag, "_hq"}, {32'd0, q}, {32'd0, q0});
        check({tag, "_hr"}, {48'd0, r}, {48'd0, r0});
        check({tag, "_hv"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_hi"}, {63'd0, in_ready}, 64'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check({tag, "_rel_v"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_rel_i"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int a;
    int b;
    logic [31:0] rn;
    logic [15:0] rd;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = '0;
    d = '0;
    #12;
    check("rst_irdy", {63'd0, in_ready}, 64'd1);
    check("rst_ov", {63'd0, out_valid}, 64'd0);
    check("rst_q", {32'd0, q}, 64'd0);
    check("rst_r", {48'd0, r}, 64'd0);
    check("rst_dz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_div("t1", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0);
    do_div("t2a", -32'sd100, 16'd7, -32'sd14, -16'sd2, 1'b0, 1'b0);
    do_div("t2b", 32'd100, -16'sd7, -32'sd14, 16'd2, 1'b0, 1'b0);
    do_div("t2c", -32'sd100, -16'sd7, 32'd14, -16'sd2, 1'b0, 1'b0);
    do_div("t3", 32'd5, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0);
    do_div("t4a", 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, 1'b0);
    do_div("t4b", 32'h8000_0000, 16'h8000, 32'd65536, 16'd0, 1'b0, 1'b0);
    do_div("t5", 32'd1000, 16'd33, 32'd30, 16'd10, 1'b0, 1'b1);

    issue(32'd12345, 16'd17);
    repeat (10) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_irdy", {63'd0, in_ready}, 64'd1);
    check("t6_ov", {63'd0, out_valid}, 64'd0);
    check("t6_q", {32'd0, q}, 64'd0);
    check("t6_r", {48'd0, r}, 64'd0);
    check("t6_dz", {63'd0, div_by_zero}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_div("t6n", 32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rn = $urandom;
      rd = 16'($urandom);
      if (i[0]) rn = {{20{rn[31]}}, rn[11:0]};
      if (rd == 16'd0) rd = 16'd3;
      if (rn == 32'h8000_0000 && rd == 16'hFFFF) rd = 16'd5;
      a = int'(rn);
      b = int'($signed(rd));
      do_div("rnd", rn, rd, 32'(a / b), 16'(a % b), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
